// File: rtl/sobel_cfg_ctrl.sv
// Register-side controller for the sobel/FIR/histogram datapath in the pixel clock domain.
// Shadows FIR coefficient writes and commits them as one burst at the vsync rising edge.
module sobel_cfg_ctrl #(
  parameter int COEF_NUM = 16,
  parameter int COEF_W   = 16,
  parameter int BIN_W    = 16,
  parameter int ADDR_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        vs_i,
  input  logic                        axi_wr_strobe_i,
  input  logic [ADDR_W-1:0]           fir_addr_from_axi,
  input  logic [COEF_W-1:0]           fir_coeff_from_axi,
  output logic                        axi_wr_ack_o,
  input  logic                        axi_rd_strobe_i,
  input  logic [ADDR_W-1:0]           hist_addr_from_axi,
  output logic [BIN_W-1:0]            hist_bin_to_axi,
  output logic                        axi_rd_ack_o,
  output logic                        fir_coef_we_o,
  output logic [$clog2(COEF_NUM)-1:0] fir_coef_addr_o,
  output logic [COEF_W-1:0]           fir_coef_data_o,
  input  logic                        hist_busy_i,
  output logic                        hist_rd_en_o,
  output logic [ADDR_W-1:0]           hist_rd_addr_o,
  input  logic [BIN_W-1:0]            hist_rd_data_i,
  output logic                        cfg_pending_o,
  output logic                        addr_err_o
);

  localparam int CAW = $clog2(COEF_NUM);
  localparam logic [ADDR_W:0]  COEF_LIM  = (ADDR_W+1)'(COEF_NUM);
  localparam logic [CAW-1:0]   LAST_IDX  = CAW'(COEF_NUM - 1);

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_HOLD} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ISSUE, R_DATA} rd_state_t;

  wr_state_t           wr_state_r;
  rd_state_t           rd_state_r;
  logic [COEF_W-1:0]   shadow_r [COEF_NUM];
  logic                vs_q_r;
  logic                dirty_r;
  logic                err_r;
  logic                wr_ack_r;
  logic                held_r;
  logic [ADDR_W-1:0]   held_addr_r;
  logic [COEF_W-1:0]   held_data_r;
  logic                we_r;
  logic [CAW-1:0]      caddr_r;
  logic [COEF_W-1:0]   cdata_r;
  logic                rd_ack_r;
  logic                rd_en_r;
  logic [ADDR_W-1:0]   rd_addr_r;
  logic [BIN_W-1:0]    bin_r;

  logic                vs_edge_s;
  logic                wr_accept_s;
  logic                wr_in_range_s;
  logic                held_in_range_s;
  logic [CAW-1:0]      wr_idx_s;
  logic                commit_go_s;
  logic [COEF_W-1:0]   data0_s;

  // Request decode; a strobe in an ack cycle is a protocol violation and is dropped
  always_comb begin
    vs_edge_s       = vs_i & ~vs_q_r;
    wr_accept_s     = axi_wr_strobe_i & ~wr_ack_r;
    wr_in_range_s   = ({1'b0, fir_addr_from_axi} < COEF_LIM);
    held_in_range_s = ({1'b0, held_addr_r} < COEF_LIM);
    wr_idx_s        = fir_addr_from_axi[CAW-1:0];
    if (wr_state_r == W_IDLE) begin
      commit_go_s = vs_edge_s & (dirty_r | (wr_accept_s & wr_in_range_s));
    end else begin
      commit_go_s = 1'b0;
    end
    // A write landing on the same edge as the commit start must reach entry 0
    if (wr_accept_s && wr_in_range_s && (wr_idx_s == '0)) begin
      data0_s = fir_coeff_from_axi;
    end else begin
      data0_s = shadow_r[0];
    end
  end

  // Write FSM: shadow updates, commit burst and writes held across a burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_r  <= W_IDLE;
      vs_q_r      <= 1'b0;
      dirty_r     <= 1'b0;
      err_r       <= 1'b0;
      wr_ack_r    <= 1'b0;
      held_r      <= 1'b0;
      held_addr_r <= '0;
      held_data_r <= '0;
      we_r        <= 1'b0;
      caddr_r     <= '0;
      cdata_r     <= '0;
      for (int i = 0; i < COEF_NUM; i++) shadow_r[i] <= '0;
    end else begin
      vs_q_r   <= vs_i;
      wr_ack_r <= 1'b0;
      case (wr_state_r)
        W_IDLE: begin
          if (wr_accept_s) begin
            wr_ack_r <= 1'b1;
            if (wr_in_range_s) shadow_r[wr_idx_s] <= fir_coeff_from_axi;
            else err_r <= 1'b1;
          end
          if (commit_go_s) begin
            wr_state_r <= W_COMMIT;
            dirty_r    <= 1'b0;
            we_r       <= 1'b1;
            caddr_r    <= '0;
            cdata_r    <= data0_s;
          end else if (wr_accept_s && wr_in_range_s) begin
            dirty_r <= 1'b1;
          end
        end
        W_COMMIT: begin
          if (wr_accept_s && !held_r) begin
            held_r      <= 1'b1;
            held_addr_r <= fir_addr_from_axi;
            held_data_r <= fir_coeff_from_axi;
          end
          if (caddr_r == LAST_IDX) begin
            we_r    <= 1'b0;
            caddr_r <= '0;
            cdata_r <= '0;
            if (held_r || wr_accept_s) begin
              wr_state_r <= W_HOLD;
              wr_ack_r   <= 1'b1;
            end else begin
              wr_state_r <= W_IDLE;
            end
          end else begin
            caddr_r <= caddr_r + CAW'(1);
            cdata_r <= shadow_r[caddr_r + CAW'(1)];
          end
        end
        W_HOLD: begin
          held_r     <= 1'b0;
          wr_state_r <= W_IDLE;
          if (held_in_range_s) begin
            shadow_r[held_addr_r[CAW-1:0]] <= held_data_r;
            dirty_r <= 1'b1;
          end else begin
            err_r <= 1'b1;
          end
        end
        default: begin
          wr_state_r <= W_IDLE;
          we_r       <= 1'b0;
          held_r     <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM: wait out histogram updates, issue one RAM read, return the bin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_r <= R_IDLE;
      rd_ack_r   <= 1'b0;
      rd_en_r    <= 1'b0;
      rd_addr_r  <= '0;
      bin_r      <= '0;
    end else begin
      rd_ack_r <= 1'b0;
      rd_en_r  <= 1'b0;
      case (rd_state_r)
        R_IDLE: begin
          if (axi_rd_strobe_i) begin
            rd_addr_r  <= hist_addr_from_axi;
            rd_state_r <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (!hist_busy_i) begin
            rd_en_r    <= 1'b1;
            rd_state_r <= R_ISSUE;
          end
        end
        R_ISSUE: begin
          rd_ack_r   <= 1'b1;
          rd_state_r <= R_DATA;
        end
        R_DATA: begin
          bin_r      <= hist_rd_data_i;
          rd_state_r <= R_IDLE;
        end
        default: rd_state_r <= R_IDLE;
      endcase
    end
  end

  // RAM data arrives in the ack cycle itself, so it is passed through until captured
  always_comb begin
    if (rd_state_r == R_DATA) begin
      hist_bin_to_axi = hist_rd_data_i;
    end else begin
      hist_bin_to_axi = bin_r;
    end
  end

  assign axi_wr_ack_o    = wr_ack_r;
  assign axi_rd_ack_o    = rd_ack_r;
  assign fir_coef_we_o   = we_r;
  assign fir_coef_addr_o = caddr_r;
  assign fir_coef_data_o = cdata_r;
  assign hist_rd_en_o    = rd_en_r;
  assign hist_rd_addr_o  = rd_addr_r;
  assign cfg_pending_o   = dirty_r;
  assign addr_err_o      = err_r;

endmodule

// File: tb/tb_sobel_cfg_ctrl.sv
// Randomized self-checking bench for sobel_cfg_ctrl with a shadow/commit and read-latency model.
module tb_sobel_cfg_ctrl;
  localparam int COEF_NUM = 16;
  localparam int COEF_W   = 16;
  localparam int BIN_W    = 16;
  localparam int ADDR_W   = 8;

  logic clk = 1'b0;
  logic rst, vs_i, axi_wr_strobe_i, axi_rd_strobe_i, hist_busy_i;
  logic [ADDR_W-1:0] fir_addr_from_axi, hist_addr_from_axi, hist_rd_addr_o;
  logic [COEF_W-1:0] fir_coeff_from_axi, fir_coef_data_o;
  logic [BIN_W-1:0]  hist_bin_to_axi, hist_rd_data_i;
  logic axi_wr_ack_o, axi_rd_ack_o, fir_coef_we_o, hist_rd_en_o, cfg_pending_o, addr_err_o;
  logic [$clog2(COEF_NUM)-1:0] fir_coef_addr_o;

  always #5 clk = ~clk;

  sobel_cfg_ctrl #(.COEF_NUM(COEF_NUM), .COEF_W(COEF_W), .BIN_W(BIN_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .vs_i(vs_i),
    .axi_wr_strobe_i(axi_wr_strobe_i), .fir_addr_from_axi(fir_addr_from_axi),
    .fir_coeff_from_axi(fir_coeff_from_axi), .axi_wr_ack_o(axi_wr_ack_o),
    .axi_rd_strobe_i(axi_rd_strobe_i), .hist_addr_from_axi(hist_addr_from_axi),
    .hist_bin_to_axi(hist_bin_to_axi), .axi_rd_ack_o(axi_rd_ack_o),
    .fir_coef_we_o(fir_coef_we_o), .fir_coef_addr_o(fir_coef_addr_o),
    .fir_coef_data_o(fir_coef_data_o), .hist_busy_i(hist_busy_i),
    .hist_rd_en_o(hist_rd_en_o), .hist_rd_addr_o(hist_rd_addr_o),
    .hist_rd_data_i(hist_rd_data_i), .cfg_pending_o(cfg_pending_o), .addr_err_o(addr_err_o)
  );

  // Histogram RAM model: registered read, data one cycle after the enable
  logic [BIN_W-1:0] mem [256];
  logic [BIN_W-1:0] ram_q = '0;
  always @(posedge clk) if (hist_rd_en_o) ram_q <= mem[hist_rd_addr_o];
  assign hist_rd_data_i = ram_q;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  // Reference model of the shadow file and flags
  logic [COEF_W-1:0] ref_shadow [COEF_NUM];
  bit ref_dirty, ref_err;

  // Observations of one commit window
  int obs_n, obs_first, obs_last, obs_ack_cnt, obs_ack_cyc;
  bit obs_order_ok;
  logic [COEF_W-1:0] obs_img [COEF_NUM];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [COEF_W-1:0] d);
    axi_wr_strobe_i = 1'b1; fir_addr_from_axi = a; fir_coeff_from_axi = d;
    tick();
    axi_wr_strobe_i = 1'b0;
    if (int'(a) < COEF_NUM) begin ref_shadow[a[3:0]] = d; ref_dirty = 1'b1; end
    else ref_err = 1'b1;
  endtask

  task automatic pulse_vs();
    vs_i = 1'b1;
    tick();
    vs_i = 1'b0;
  endtask

  // Watches max_cyc cycles starting with the current one; optionally strobes a write
  // during the inj_at-th commit cycle
  task automatic observe_burst(input int max_cyc, input int inj_at,
                               input logic [ADDR_W-1:0] ia, input logic [COEF_W-1:0] id);
    obs_n = 0; obs_first = -1; obs_last = -1; obs_ack_cnt = 0; obs_ack_cyc = -1; obs_order_ok = 1'b1;
    for (int k = 0; k < COEF_NUM; k++) obs_img[k] = 'x;
    for (int i = 0; i < max_cyc; i++) begin
      if (fir_coef_we_o) begin
        if (obs_n == 0) obs_first = cyc;
        if (int'(fir_coef_addr_o) != obs_n) obs_order_ok = 1'b0;
        obs_img[fir_coef_addr_o] = fir_coef_data_o;
        obs_n++;
        obs_last = cyc;
      end
      if (axi_wr_ack_o) begin obs_ack_cnt++; obs_ack_cyc = cyc; end
      if (fir_coef_we_o && obs_n == inj_at) begin
        axi_wr_strobe_i = 1'b1; fir_addr_from_axi = ia; fir_coeff_from_axi = id;
      end
      tick();
      axi_wr_strobe_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vs_i = 1'b0; axi_wr_strobe_i = 1'b0; axi_rd_strobe_i = 1'b0; hist_busy_i = 1'b0;
    fir_addr_from_axi = '0; fir_coeff_from_axi = '0; hist_addr_from_axi = '0;
    repeat (3) tick();
    n_tests++; if ({axi_wr_ack_o, axi_rd_ack_o, fir_coef_we_o, hist_rd_en_o, cfg_pending_o, addr_err_o} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000", {axi_wr_ack_o, axi_rd_ack_o, fir_coef_we_o, hist_rd_en_o, cfg_pending_o, addr_err_o}); end
    n_tests++; if ({fir_coef_addr_o, fir_coef_data_o, hist_rd_addr_o, hist_bin_to_axi} !== '0) begin
      n_fail++; $display("FAIL reset_buses: got %h %h %h %h want 0", fir_coef_addr_o, fir_coef_data_o, hist_rd_addr_o, hist_bin_to_axi); end
    rst = 1'b0;
    for (int k = 0; k < COEF_NUM; k++) ref_shadow[k] = '0;
    ref_dirty = 1'b0; ref_err = 1'b0;
    repeat (2) tick();
    n_tests++; if ({axi_wr_ack_o, fir_coef_we_o, cfg_pending_o, addr_err_o} !== 4'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want 0000", {axi_wr_ack_o, fir_coef_we_o, cfg_pending_o, addr_err_o}); end
  endtask

  task automatic test_vs_no_dirty();
    pulse_vs();
    observe_burst(20, -1, '0, '0);
    n_tests++; if (obs_n != 0) begin n_fail++; $display("FAIL vs_clean_no_we: got %0d we cycles want 0", obs_n); end
  endtask

  // Commit one burst and compare everything against the reference shadow
  task automatic test_commit_check(input string tag);
    n_tests++; if (cfg_pending_o !== ref_dirty) begin n_fail++; $display("FAIL %s_pending_pre: got %b want %b", tag, cfg_pending_o, ref_dirty); end
    pulse_vs();
    ref_dirty = 1'b0;
    n_tests++; if (cfg_pending_o !== 1'b0) begin n_fail++; $display("FAIL %s_pending_clr: got %b want 0", tag, cfg_pending_o); end
    observe_burst(24, -1, '0, '0);
    n_tests++; if (obs_n != COEF_NUM || !obs_order_ok || obs_last - obs_first != COEF_NUM - 1) begin
      n_fail++; $display("FAIL %s_burst_shape: got n=%0d order=%0d span=%0d want n=16 order=1 span=15", tag, obs_n, obs_order_ok, obs_last - obs_first); end
    for (int k = 0; k < COEF_NUM; k++) begin
      n_tests++; if (obs_img[k] !== ref_shadow[k]) begin n_fail++; $display("FAIL %s_coef[%0d]: got %h want %h", tag, k, obs_img[k], ref_shadow[k]); end
    end
  endtask

  task automatic test_write_commit();
    do_write(8'd3, 16'h1234);
    n_tests++; if (axi_wr_ack_o !== 1'b1) begin n_fail++; $display("FAIL wr_ack_t1: got %b want 1", axi_wr_ack_o); end
    tick();
    n_tests++; if (axi_wr_ack_o !== 1'b0) begin n_fail++; $display("FAIL wr_ack_single: got %b want 0", axi_wr_ack_o); end
    test_commit_check("plan_a3");
    for (int r = 0; r < 3; r++) begin
      int nw;
      nw = $urandom_range(1, 5);
      for (int w = 0; w < nw; w++) begin
        do_write(8'($urandom_range(0, COEF_NUM - 1)), 16'($urandom));
        n_tests++; if (axi_wr_ack_o !== 1'b1) begin n_fail++; $display("FAIL rand_wr_ack: got %b want 1", axi_wr_ack_o); end
        repeat ($urandom_range(1, 3)) tick();
      end
      test_commit_check("rand");
    end
  endtask

  task automatic test_write_during_commit();
    do_write(8'd0, 16'($urandom));
    tick();
    pulse_vs();
    ref_dirty = 1'b0;
    observe_burst(30, 4, 8'd5, 16'hBEEF);
    n_tests++; if (obs_n != COEF_NUM) begin n_fail++; $display("FAIL hold_burst_len: got %0d want 16", obs_n); end
    n_tests++; if (obs_ack_cnt != 1 || obs_ack_cyc != obs_last + 1) begin
      n_fail++; $display("FAIL hold_ack_time: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", obs_ack_cnt, obs_ack_cyc, obs_last + 1); end
    for (int k = 0; k < COEF_NUM; k++) begin
      n_tests++; if (obs_img[k] !== ref_shadow[k]) begin n_fail++; $display("FAIL hold_old_coef[%0d]: got %h want %h", k, obs_img[k], ref_shadow[k]); end
    end
    ref_shadow[5] = 16'hBEEF; ref_dirty = 1'b1;
    n_tests++; if (cfg_pending_o !== 1'b1) begin n_fail++; $display("FAIL hold_pending: got %b want 1", cfg_pending_o); end
    test_commit_check("hold_next");
  endtask

  task automatic test_addr_err();
    do_write(8'd20, 16'hFFFF);
    n_tests++; if (axi_wr_ack_o !== 1'b1) begin n_fail++; $display("FAIL err_ack: got %b want 1", axi_wr_ack_o); end
    n_tests++; if (addr_err_o !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", addr_err_o); end
    n_tests++; if (cfg_pending_o !== ref_dirty) begin n_fail++; $display("FAIL err_pending: got %b want %b", cfg_pending_o, ref_dirty); end
    repeat (5) tick();
    do_write(8'($urandom_range(0, COEF_NUM - 1)), 16'($urandom));
    tick();
    test_commit_check("after_err");
    n_tests++; if (addr_err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", addr_err_o); end
  endtask

  task automatic test_write_vs_same();
    for (int r = 0; r < 2; r++) begin
      logic [ADDR_W-1:0] a;
      logic [COEF_W-1:0] d;
      a = (r == 0) ? 8'd0 : 8'($urandom_range(1, COEF_NUM - 1));
      d = 16'($urandom);
      axi_wr_strobe_i = 1'b1; fir_addr_from_axi = a; fir_coeff_from_axi = d; vs_i = 1'b1;
      tick();
      axi_wr_strobe_i = 1'b0; vs_i = 1'b0;
      ref_shadow[a[3:0]] = d; ref_dirty = 1'b0;
      n_tests++; if ({axi_wr_ack_o, fir_coef_we_o} !== 2'b11) begin n_fail++; $display("FAIL same_ack_we: got %b want 11", {axi_wr_ack_o, fir_coef_we_o}); end
      observe_burst(22, -1, '0, '0);
      n_tests++; if (obs_n != COEF_NUM || obs_ack_cnt != 1 || obs_ack_cyc != obs_first) begin
        n_fail++; $display("FAIL same_shape: got n=%0d acks=%0d ackcyc=%0d want n=16 acks=1 ackcyc=%0d", obs_n, obs_ack_cnt, obs_ack_cyc, obs_first); end
      for (int k = 0; k < COEF_NUM; k++) begin
        n_tests++; if (obs_img[k] !== ref_shadow[k]) begin n_fail++; $display("FAIL same_coef[%0d]: got %h want %h", k, obs_img[k], ref_shadow[k]); end
      end
      n_tests++; if (cfg_pending_o !== 1'b0) begin n_fail++; $display("FAIL same_pending: got %b want 0", cfg_pending_o); end
    end
  endtask

  task automatic test_read_random();
    for (int r = 0; r < 10; r++) begin
      bit pat [48];
      int t0, k, exp_ack, got_ack;
      logic [ADDR_W-1:0] a;
      logic [BIN_W-1:0] exp_d;
      a = (r < 2) ? 8'd7 : 8'($urandom_range(0, 255));
      for (int j = 0; j < 48; j++) pat[j] = (j < 20) && ($urandom_range(0, 2) == 0);
      if (r == 0) for (int j = 0; j < 48; j++) pat[j] = 1'b0;
      if (r == 1) for (int j = 0; j < 48; j++) pat[j] = (j >= 1 && j <= 10);
      k = 1;
      while (pat[k]) k++;
      t0 = cyc; exp_ack = t0 + k + 2; exp_d = mem[a];
      axi_rd_strobe_i = 1'b1; hist_addr_from_axi = a; hist_busy_i = 1'b0;
      tick();
      axi_rd_strobe_i = 1'b0;
      got_ack = -1;
      for (int i = 1; i < 40 && got_ack < 0; i++) begin
        hist_busy_i = pat[i];
        if (axi_rd_ack_o) got_ack = cyc;
        else tick();
      end
      hist_busy_i = 1'b0;
      n_tests++; if (got_ack != exp_ack) begin n_fail++; $display("FAIL rd_latency[%0d]: got ack cycle %0d want %0d", r, got_ack, exp_ack); end
      n_tests++; if (hist_bin_to_axi !== exp_d) begin n_fail++; $display("FAIL rd_data[%0d]: got %h want %h", r, hist_bin_to_axi, exp_d); end
      tick();
      n_tests++; if (axi_rd_ack_o !== 1'b0 || hist_bin_to_axi !== exp_d) begin
        n_fail++; $display("FAIL rd_hold[%0d]: got ack=%b data=%h want ack=0 data=%h", r, axi_rd_ack_o, hist_bin_to_axi, exp_d); end
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] wa;
    logic [COEF_W-1:0] wd;
    ra = 8'($urandom_range(0, 255));
    wa = 8'($urandom_range(0, COEF_NUM - 1));
    wd = 16'($urandom);
    axi_rd_strobe_i = 1'b1; hist_addr_from_axi = ra; hist_busy_i = 1'b0;
    do_write(wa, wd);
    axi_rd_strobe_i = 1'b0;
    n_tests++; if ({axi_wr_ack_o, axi_rd_ack_o} !== 2'b10) begin n_fail++; $display("FAIL b2b_t1: got %b want 10", {axi_wr_ack_o, axi_rd_ack_o}); end
    tick(); tick();
    n_tests++; if (axi_rd_ack_o !== 1'b1 || hist_bin_to_axi !== mem[ra]) begin
      n_fail++; $display("FAIL b2b_read: got ack=%b data=%h want ack=1 data=%h", axi_rd_ack_o, hist_bin_to_axi, mem[ra]); end
    test_commit_check("b2b");
  endtask

  task automatic test_reset_mid_commit();
    int acks, wes;
    do_write(8'd9, 16'($urandom));
    tick();
    pulse_vs();
    repeat (7) tick();
    n_tests++; if (fir_coef_we_o !== 1'b1 || fir_coef_addr_o !== 4'd7) begin
      n_fail++; $display("FAIL rstmid_pre: got we=%b addr=%0d want we=1 addr=7", fir_coef_we_o, fir_coef_addr_o); end
    rst = 1'b1;
    #1;
    n_tests++; if ({fir_coef_we_o, cfg_pending_o, addr_err_o} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_async: got %b want 000", {fir_coef_we_o, cfg_pending_o, addr_err_o}); end
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < COEF_NUM; k++) ref_shadow[k] = '0;
    ref_dirty = 1'b0; ref_err = 1'b0;
    acks = 0; wes = 0;
    for (int i = 0; i < 10; i++) begin
      if (axi_wr_ack_o) acks++;
      if (fir_coef_we_o) wes++;
      tick();
    end
    n_tests++; if (acks != 0 || wes != 0) begin n_fail++; $display("FAIL rstmid_quiet: got acks=%0d we=%0d want 0 0", acks, wes); end
    pulse_vs();
    observe_burst(20, -1, '0, '0);
    n_tests++; if (obs_n != 0) begin n_fail++; $display("FAIL rstmid_no_commit: got %0d we cycles want 0", obs_n); end
    do_write(8'd1, 16'($urandom));
    tick();
    test_commit_check("rstmid_shadow");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[7] = 16'h00AA;
    test_reset();
    test_vs_no_dirty();
    test_write_commit();
    test_write_during_commit();
    test_addr_err();
    test_write_vs_same();
    test_read_random();
    test_back_to_back();
    test_reset_mid_commit();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
